lbm_stream_pull: RTL and testbench



---
 rtl/lbm_pkg.sv | 24 ++
 rtl/lbm_stream_pull_if.sv | 38 +++
 rtl/lbm_neighbour_addr.sv | 50 +++++
 rtl/lbm_stream_pull.sv | 133 +++++++++++++
 tb/tb_lbm_stream_pull.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lbm_pkg.sv
// Shared D2Q9 constants for the LBM streaming datapath:
// direction set, opposite mapping and pull offsets.
package lbm_pkg;

    localparam int Q = 9;

    typedef enum logic [3:0] {
        D_REST, D_N, D_NE, D_E, D_SE,
        D_S, D_SW, D_W, D_NW
    } dir_e;

    typedef enum logic [1:0] {
        S_IDLE, S_SWEEP, S_DRAIN, S_DONE
    } state_e;

    // Offset from a destination cell to the cell it pulls from (row 0 = top)
    localparam int ROW_OFF [Q] = '{0, 1, 1, 0, -1, -1, -1, 0, 1};
    localparam int COL_OFF [Q] = '{0, 0, -1, -1, -1, 0, 1, 1, 1};

    function automatic int opp(input int d);
        return (d == 0) ? 0 : ((d + 3) % 8) + 1;
    endfunction

endpackage

// File: rtl/lbm_stream_pull_if.sv
// Control, mode and population-RAM bus of the streaming engine.
// master = engine side, slave = collision stage / RAM side.
interface lbm_stream_pull_if
    import lbm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CELLS      = 256,
    parameter int ADDR_WIDTH = $clog2(CELLS)
);

    logic                                start;
    logic                                periodic;
    logic                                zero_solid;
    logic [CELLS-1:0]                    barrier_mask;
    logic                                busy;
    logic                                done;
    logic                                bank;
    logic [Q-1:0][ADDR_WIDTH-1:0]        rd_addr;
    logic [Q-1:0][DATA_WIDTH-1:0]        rd_data;
    logic                                wr_en;
    logic [ADDR_WIDTH-1:0]               wr_addr;
    logic [Q-1:0][DATA_WIDTH-1:0]        wr_data;

    modport master (
        input  start, periodic, zero_solid,
        input  barrier_mask, rd_data,
        output busy, done, bank,
        output rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, periodic, zero_solid,
        output barrier_mask, rd_data,
        input  busy, done, bank,
        input  rd_addr, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/lbm_neighbour_addr.sv
// Combinational pull-source address generator for one destination cell.
module lbm_neighbour_addr
    import lbm_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16,
    parameter int RW     = 4,
    parameter int CW     = 4,
    parameter int AW     = 8
) (
    input  logic [RW-1:0]         row_i,
    input  logic [CW-1:0]         col_i,
    input  logic                  periodic_i,
    input  logic                  solid_i,
    output logic [Q-1:0][AW-1:0]  addr_o
);

    int   r;
    int   c;
    logic off;

    always_comb begin
        r      = 0;
        c      = 0;
        off    = 1'b0;
        addr_o = '0;
        for (int d = 0; d < Q; d++) begin
            r   = int'(row_i) + ROW_OFF[d];
            c   = int'(col_i) + COL_OFF[d];
            off = (r < 0) || (r >= GRID_H) ||
                  (c < 0) || (c >= GRID_W);
            if (periodic_i) begin
                if (r < 0)            r = r + GRID_H;
                else if (r >= GRID_H) r = r - GRID_H;
                if (c < 0)            c = c + GRID_W;
                else if (c >= GRID_W) c = c - GRID_W;
            end else if (off) begin
                r = int'(row_i);
                c = int'(col_i);
            end
            // Solid cells read all directions in place for bounce-back
            if (solid_i) begin
                r = int'(row_i);
                c = int'(col_i);
            end
            addr_o[d] = AW'(r * GRID_W + c);
        end
    end

endmodule

// File: rtl/lbm_stream_pull.sv
// D2Q9 pull-streaming engine with fused bounce-back, one cell per cycle
// between ping-pong population banks.
module lbm_stream_pull
    import lbm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 16,
    parameter int CELLS      = GRID_W * GRID_H,
    parameter int ADDR_WIDTH = $clog2(CELLS)
) (
    input logic             clk,
    input logic             rst,
    lbm_stream_pull_if.master bus
);

    localparam int RW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int CW = (GRID_W > 1) ? $clog2(GRID_W) : 1;

    state_e                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        idx_q;
    logic [RW-1:0]                row_q;
    logic [CW-1:0]                col_q;
    logic                         periodic_q;
    logic                         zero_q;
    logic                         solid_q;
    logic                         wr_en_q;
    logic [ADDR_WIDTH-1:0]        wr_addr_q;
    logic                         bank_q;
    logic [Q-1:0][ADDR_WIDTH-1:0] nb_addr;
    logic                         last;

    assign last = (idx_q == ADDR_WIDTH'(CELLS - 1));

    lbm_neighbour_addr #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .RW     (RW),
        .CW     (CW),
        .AW     (ADDR_WIDTH)
    ) u_nb (
        .row_i      (row_q),
        .col_i      (col_q),
        .periodic_i (periodic_q),
        .solid_i    (bus.barrier_mask[idx_q]),
        .addr_o     (nb_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_SWEEP;
            S_SWEEP: if (last) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.rd_addr = '0;
        unique case (state_q)
            S_SWEEP: begin
                bus.busy    = 1'b1;
                bus.rd_addr = nb_addr;
            end
            S_DRAIN: bus.busy = 1'b1;
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            periodic_q <= 1'b0;
            zero_q     <= 1'b0;
            solid_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            bank_q     <= 1'b0;
        end else begin
            // Write stage trails the read issue by the RAM latency
            wr_en_q   <= (state_q == S_SWEEP);
            wr_addr_q <= idx_q;
            solid_q   <= bus.barrier_mask[idx_q];
            unique case (state_q)
                S_IDLE: if (bus.start) begin
                    idx_q      <= '0;
                    row_q      <= '0;
                    col_q      <= '0;
                    periodic_q <= bus.periodic;
                    zero_q     <= bus.zero_solid;
                end
                S_SWEEP: begin
                    idx_q <= idx_q + 1'b1;
                    if (col_q == CW'(GRID_W - 1)) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                S_DONE:  bank_q <= ~bank_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.wr_data = '0;
        if (wr_en_q) begin
            for (int d = 0; d < Q; d++) begin
                if (!solid_q)    bus.wr_data[d] = bus.rd_data[d];
                else if (!zero_q) bus.wr_data[d] = bus.rd_data[opp(d)];
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.bank    = bank_q;

endmodule

// File: tb/tb_lbm_stream_pull.sv
// Bench for lbm_stream_pull on a 4x4 lattice with ping-pong RAM models
// and a velocity-vector reference of the streaming step.
module tb_lbm_stream_pull;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int DW = 16;

    logic clk;
    logic rst;

    lbm_stream_pull_if #(.DATA_WIDTH(DW), .CELLS(N)) bus ();

    lbm_stream_pull #(
        .DATA_WIDTH (DW),
        .GRID_W     (W),
        .GRID_H     (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem   [2][9][N];
    logic [15:0] src_m [9][N];
    logic [15:0] exp_m [9][N];

    int cyc      = 0;
    int wcnt     = 0;
    int pass_cnt = 0;
    int tot_cnt  = 0;
    int last_db  = 0;
    bit exp_bank = 1'b0;

    // Particle velocity per direction: row step, column step (row 0 = top)
    int ER [9] = '{0, -1, -1, 0, 1, 1, 1, 0, -1};
    int EC [9] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int d = 0; d < 9; d++) begin
            bus.rd_data[d] <= mem[bus.bank][d][bus.rd_addr[d]];
            if (bus.wr_en === 1'b1)
                mem[~bus.bank][d][bus.wr_addr] = bus.wr_data[d];
        end
        if (bus.wr_en === 1'b1) wcnt = wcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        tot_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic int opp_m(input int d);
        int r = 0;
        for (int e = 0; e < 9; e++)
            if (ER[e] == -ER[d] && EC[e] == -EC[d]) r = e;
        return r;
    endfunction

    task automatic model(input bit per, input bit zs,
                         input logic [15:0] mask);
        for (int j = 0; j < N; j++) begin
            int r, c, sr, sc;
            r = j / W;
            c = j % W;
            for (int d = 0; d < 9; d++) begin
                if (mask[j]) begin
                    exp_m[d][j] = zs ? 16'h0 : src_m[opp_m(d)][j];
                end else begin
                    sr = r - ER[d];
                    sc = c - EC[d];
                    if (sr < 0 || sr >= H || sc < 0 || sc >= W) begin
                        if (per) begin
                            sr = (sr + H) % H;
                            sc = (sc + W) % W;
                        end else begin
                            sr = r;
                            sc = c;
                        end
                    end
                    exp_m[d][j] = src_m[d][sr * W + sc];
                end
            end
        end
    endtask

    task automatic preload(input bit sb);
        for (int d = 0; d < 9; d++)
            for (int j = 0; j < N; j++) begin
                mem[sb][d][j]  = src_m[d][j];
                mem[!sb][d][j] = 16'hDEAD;
            end
    endtask

    task automatic clear_src();
        for (int d = 0; d < 9; d++)
            for (int j = 0; j < N; j++) src_m[d][j] = 16'h0;
    endtask

    task automatic rand_src();
        for (int d = 0; d < 9; d++)
            for (int j = 0; j < N; j++) src_m[d][j] = 16'($urandom);
    endtask

    task automatic check_dest(input int db);
        for (int d = 0; d < 9; d++)
            for (int j = 0; j < N; j++)
                chk($sformatf("dst d%0d c%0d", d, j),
                    32'(mem[db][d][j]), 32'(exp_m[d][j]));
    endtask

    task automatic wait_done(input int exp_cyc, input bit tog);
        for (int n = 0; n < 60 && bus.done !== 1'b1; n++) begin
            if (tog && (n == 5 || n == 10)) bus.periodic = ~bus.periodic;
            @(negedge clk);
        end
        chk("done_cyc", 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic run_step(input bit per, input bit zs,
                            input logic [15:0] mask);
        int s, w0;
        preload(exp_bank);
        model(per, zs, mask);
        bus.periodic     = per;
        bus.zero_solid   = zs;
        bus.barrier_mask = mask;
        s  = cyc;
        w0 = wcnt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_s1", 32'(bus.busy), 32'd1);
        bus.periodic   = ~per;
        bus.zero_solid = ~zs;
        wait_done(s + 18, 1'b0);
        last_db = exp_bank ? 0 : 1;
        check_dest(last_db);
        chk("wr_count", 32'(wcnt - w0), 32'd16);
        exp_bank = ~exp_bank;
        @(negedge clk);
        chk("bank", 32'(bus.bank), 32'(exp_bank));
        chk("done_low", 32'(bus.done), 32'd0);
    endtask

    initial begin
        int s, w0;
        bit per, zs;
        logic [15:0] mask;

        rst              = 1'b1;
        bus.start        = 1'b1;
        bus.periodic     = 1'b0;
        bus.zero_solid   = 1'b0;
        bus.barrier_mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_bank", 32'(bus.bank), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_rd_addr", 32'(|bus.rd_addr), 32'd0);
        chk("rst_wr_data", 32'(|bus.wr_data), 32'd0);
        w0 = wcnt;
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_start_nowr", 32'(wcnt - w0), 32'd0);
        chk("rst_start_idle", 32'(bus.busy), 32'd0);

        // Single E population moves one column east
        clear_src();
        src_m[3][5] = 16'd100;
        run_step(1'b1, 1'b0, 16'h0);
        chk("e6_100", 32'(mem[last_db][3][6]), 32'd100);

        // Left-edge east pull: wrap vs zero-gradient
        clear_src();
        src_m[3][7] = 16'd50;
        src_m[3][4] = 16'd7;
        run_step(1'b1, 1'b0, 16'h0);
        chk("wrap_per", 32'(mem[last_db][3][4]), 32'd50);
        run_step(1'b0, 1'b0, 16'h0);
        chk("wrap_open", 32'(mem[last_db][3][4]), 32'd7);

        // Solid cell 5: bounce-back, then zeroing
        clear_src();
        src_m[1][5] = 16'd30;
        src_m[5][5] = 16'd11;
        run_step(1'b0, 1'b0, 16'h0020);
        chk("bb_s5", 32'(mem[last_db][5][5]), 32'd30);
        chk("bb_n5", 32'(mem[last_db][1][5]), 32'd11);
        run_step(1'b1, 1'b1, 16'h0020);
        for (int d = 0; d < 9; d++)
            chk($sformatf("zero_d%0d", d), 32'(mem[last_db][d][5]), 32'd0);

        // Random populations, masks and modes
        for (int t = 0; t < 4; t++) begin
            rand_src();
            per  = 1'($urandom_range(0, 1));
            zs   = 1'($urandom_range(0, 1));
            mask = 16'($urandom) & 16'($urandom);
            run_step(per, zs, mask);
        end

        // start held for three back-to-back timesteps
        rand_src();
        mask = 16'($urandom) & 16'($urandom);
        preload(exp_bank);
        bus.periodic     = 1'b1;
        bus.zero_solid   = 1'b0;
        bus.barrier_mask = mask;
        s = cyc;
        bus.start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            model(1'b1, 1'b0, mask);
            wait_done(s + 18 + 19 * i, 1'b1);
            check_dest(exp_bank ? 0 : 1);
            if (i == 2) bus.start = 1'b0;
            exp_bank = ~exp_bank;
            src_m = exp_m;
            @(negedge clk);
            chk($sformatf("held_bank%0d", i), 32'(bus.bank), 32'(exp_bank));
        end
        repeat (3) @(negedge clk);
        chk("held_stops", 32'(bus.busy), 32'd0);

        // Reset in the middle of a sweep
        rand_src();
        preload(exp_bank);
        bus.barrier_mask = 16'h0;
        s = cyc;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < s + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("mid_rst_bank", 32'(bus.bank), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        exp_bank = 1'b0;
        w0 = wcnt;
        repeat (3) @(negedge clk);
        chk("mid_rst_nowr", 32'(wcnt - w0), 32'd0);
        chk("mid_rst_nodone", 32'(bus.done), 32'd0);
        rand_src();
        run_step(1'b1, 1'b0, 16'h0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
